// File: rtl/alarm_light_driver_if.sv
// Signal bundle between the alarm comparator, clock divider and buttons
// on one side and the alarm light driver on the other.
interface alarm_light_driver_if #(
  parameter int LED_W = 16
);
  logic             tick_1hz;
  logic             tick_fast;
  logic             start_light_alarm;
  logic             stop_btn;
  logic             snooze_btn;
  logic [LED_W-1:0] led;
  logic             ringing;
  logic             snoozing;
  logic             missed;

  // Producer side: ticks, alarm level and buttons; observes the LED/status outputs
  modport master (
    output tick_1hz, tick_fast, start_light_alarm, stop_btn, snooze_btn,
    input  led, ringing, snoozing, missed
  );

  // Driver side
  modport slave (
    input  tick_1hz, tick_fast, start_light_alarm, stop_btn, snooze_btn,
    output led, ringing, snoozing, missed
  );
endinterface

// File: rtl/alarm_light_driver.sv
// Alarm light driver: edge-detects the alarm match level and runs the
// wake-up sequence (chasing LED ring, stop, snooze with bounded count,
// automatic re-ring after snooze, sticky missed flag on ring timeout).
module alarm_light_driver #(
  parameter int LED_W       = 16,
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic                 clk,
  input  logic                 CR,
  alarm_light_driver_if.slave  bus
);

  localparam int SEC_MAX = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int SEC_W   = (SEC_MAX > 1) ? $clog2(SEC_MAX) : 1;
  localparam int SNZ_W   = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  localparam logic [SEC_W-1:0] RING_LAST   = SEC_W'(RING_SECS - 1);
  localparam logic [SEC_W-1:0] SNOOZE_LAST = SEC_W'(SNOOZE_SECS - 1);
  localparam logic [SNZ_W-1:0] SNZ_LIMIT   = SNZ_W'(MAX_SNOOZE);
  localparam logic [LED_W-1:0] LED_FIRST   = {{(LED_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [SEC_W-1:0] sec_cnt_q, sec_cnt_d;
  logic [SNZ_W-1:0] snooze_cnt_q, snooze_cnt_d;
  logic             start_q, start_d;
  logic             missed_q, missed_d;
  logic             ringing_q, ringing_d;
  logic             snoozing_q, snoozing_d;
  logic             trig;

  // Rising edge of the comparator level; a held level never retriggers
  assign trig = bus.start_light_alarm & ~start_q;

  // Next-state and registered-output computation
  always_comb begin
    state_d      = state_q;
    led_d        = led_q;
    sec_cnt_d    = sec_cnt_q;
    snooze_cnt_d = snooze_cnt_q;
    missed_d     = missed_q;
    start_d      = bus.start_light_alarm;

    unique case (state_q)
      IDLE: begin
        led_d = '0;
        if (trig) begin
          state_d      = RING;
          sec_cnt_d    = '0;
          snooze_cnt_d = '0;
          led_d        = LED_FIRST;
        end else if (bus.stop_btn) begin
          missed_d = 1'b0;
        end
      end

      RING: begin
        // Chase step and second count both apply in the same clk if coincident
        if (bus.tick_fast) led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
        if (bus.tick_1hz)  sec_cnt_d = sec_cnt_q + SEC_W'(1);
        if (bus.stop_btn) begin
          state_d = IDLE;
          led_d   = '0;
        end else if (bus.snooze_btn && (snooze_cnt_q < SNZ_LIMIT)) begin
          state_d      = SNOOZE;
          snooze_cnt_d = snooze_cnt_q + SNZ_W'(1);
          sec_cnt_d    = '0;
          led_d        = '0;
        end else if (bus.tick_1hz && (sec_cnt_q == RING_LAST)) begin
          state_d  = IDLE;
          missed_d = 1'b1;
          led_d    = '0;
        end
      end

      SNOOZE: begin
        led_d = '0;
        if (bus.stop_btn) begin
          state_d = IDLE;
        end else if (trig) begin
          // A fresh alarm event cuts the snooze short but keeps the snooze budget
          state_d   = RING;
          sec_cnt_d = '0;
          led_d     = LED_FIRST;
        end else if (bus.tick_1hz) begin
          if (sec_cnt_q == SNOOZE_LAST) begin
            state_d   = RING;
            sec_cnt_d = '0;
            led_d     = LED_FIRST;
          end else begin
            sec_cnt_d = sec_cnt_q + SEC_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        led_d   = '0;
      end
    endcase

    ringing_d  = (state_d == RING);
    snoozing_d = (state_d == SNOOZE);
  end

  // State, counters, edge-detect and output registers; CR aborts at once
  always_ff @(posedge clk or posedge CR) begin
    if (CR) begin
      state_q      <= IDLE;
      led_q        <= '0;
      sec_cnt_q    <= '0;
      snooze_cnt_q <= '0;
      start_q      <= 1'b0;
      missed_q     <= 1'b0;
      ringing_q    <= 1'b0;
      snoozing_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      led_q        <= led_d;
      sec_cnt_q    <= sec_cnt_d;
      snooze_cnt_q <= snooze_cnt_d;
      start_q      <= start_d;
      missed_q     <= missed_d;
      ringing_q    <= ringing_d;
      snoozing_q   <= snoozing_d;
    end
  end

  assign bus.led      = led_q;
  assign bus.ringing  = ringing_q;
  assign bus.snoozing = snoozing_q;
  assign bus.missed   = missed_q;

endmodule

// File: tb/tb_alarm_light_driver.sv
// Bench for alarm_light_driver: directed scenarios plus randomized traffic
// checked against a behavioural model of the wake-up sequence.
module tb_alarm_light_driver;
  localparam int LED_W       = 16;
  localparam int RING_SECS   = 4;
  localparam int SNOOZE_SECS = 3;
  localparam int MAX_SNOOZE  = 2;

  logic clk;
  logic CR;
  int   checks;
  int   failures;

  alarm_light_driver_if #(.LED_W(LED_W)) bus ();

  alarm_light_driver #(
    .LED_W(LED_W), .RING_SECS(RING_SECS),
    .SNOOZE_SECS(SNOOZE_SECS), .MAX_SNOOZE(MAX_SNOOZE)
  ) dut (
    .clk(clk),
    .CR (CR),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: mode flags, LED position, elapsed seconds, snoozes used
  bit m_ring, m_snz, m_missed, m_prev;
  int m_pos, m_elapsed, m_used;

  function automatic void model_reset();
    m_ring = 0; m_snz = 0; m_missed = 0; m_prev = 0;
    m_pos = 0; m_elapsed = 0; m_used = 0;
  endfunction

  function automatic void model_step(bit s, bit t1, bit tf, bit st, bit sn);
    bit trig;
    trig   = s && !m_prev;
    m_prev = s;
    if (m_ring) begin
      if (tf) m_pos = (m_pos + 1) % LED_W;
      if (t1) m_elapsed++;
      if (st) m_ring = 0;
      else if (sn && m_used < MAX_SNOOZE) begin
        m_ring = 0; m_snz = 1; m_used++; m_elapsed = 0;
      end else if (t1 && m_elapsed == RING_SECS) begin
        m_ring = 0; m_missed = 1;
      end
    end else if (m_snz) begin
      if (st) m_snz = 0;
      else if (trig) begin
        m_snz = 0; m_ring = 1; m_elapsed = 0; m_pos = 0;
      end else if (t1) begin
        m_elapsed++;
        if (m_elapsed == SNOOZE_SECS) begin
          m_snz = 0; m_ring = 1; m_elapsed = 0; m_pos = 0;
        end
      end
    end else begin
      if (trig) begin
        m_ring = 1; m_elapsed = 0; m_used = 0; m_pos = 0;
      end else if (st) m_missed = 0;
    end
  endfunction

  function automatic logic [LED_W-1:0] model_led();
    logic [LED_W-1:0] one;
    one = 1;
    return m_ring ? (one << m_pos) : '0;
  endfunction

  // Apply one clk of stimulus, advance the model, land 1 time unit after the edge
  task automatic drive(input bit s, input bit t1, input bit tf, input bit st, input bit sn);
    @(negedge clk);
    bus.start_light_alarm = s;
    bus.tick_1hz          = t1;
    bus.tick_fast         = tf;
    bus.stop_btn          = st;
    bus.snooze_btn        = sn;
    @(posedge clk);
    model_step(s, t1, tf, st, sn);
    #1;
  endtask

  task automatic do_reset();
    bus.start_light_alarm = 0;
    bus.tick_1hz = 0; bus.tick_fast = 0;
    bus.stop_btn = 0; bus.snooze_btn = 0;
    CR = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    CR = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    bus.start_light_alarm = 0;
    bus.tick_1hz = 0; bus.tick_fast = 0;
    bus.stop_btn = 0; bus.snooze_btn = 0;
    CR = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.led !== 16'h0000 || bus.ringing !== 1'b0 || bus.snoozing !== 1'b0 || bus.missed !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: led=%h ring=%b snz=%b missed=%b required 0000 0 0 0",
               bus.led, bus.ringing, bus.snoozing, bus.missed);
    end
    @(negedge clk);
    CR = 1'b0;
    model_reset();
    drive(0, 1, 1, 0, 1);
    checks++;
    if (bus.ringing !== 1'b0 || bus.led !== 16'h0000) begin
      failures++;
      $display("FAIL idle_ignores_ticks: ring=%b led=%h required 0 0000", bus.ringing, bus.led);
    end
  endtask

  task automatic test_trigger();
    do_reset();
    drive(1, 0, 0, 0, 0);
    checks++;
    if (bus.ringing !== 1'b1 || bus.led !== 16'h0001 || bus.snoozing !== 1'b0) begin
      failures++;
      $display("FAIL trig_enter: ring=%b led=%h snz=%b required 1 0001 0", bus.ringing, bus.led, bus.snoozing);
    end
    repeat (3) drive(1, 0, 1, 0, 0);
    checks++;
    if (bus.led !== 16'h0008) begin
      failures++;
      $display("FAIL chase_3: led=%h required 0008", bus.led);
    end
    repeat (13) drive(1, 0, 1, 0, 0);
    checks++;
    if (bus.led !== 16'h0001 || bus.ringing !== 1'b1) begin
      failures++;
      $display("FAIL chase_wrap: led=%h ring=%b required 0001 1", bus.led, bus.ringing);
    end
    drive(1, 0, 1, 0, 0);
    repeat (3) drive(1, 0, 0, 0, 0);
    checks++;
    if (bus.led !== 16'h0002) begin
      failures++;
      $display("FAIL held_level_no_retrig: led=%h required 0002", bus.led);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    repeat (RING_SECS - 1) drive(0, 1, 0, 0, 0);
    checks++;
    if (bus.ringing !== 1'b1 || bus.missed !== 1'b0) begin
      failures++;
      $display("FAIL before_timeout: ring=%b missed=%b required 1 0", bus.ringing, bus.missed);
    end
    drive(0, 1, 0, 0, 0);
    checks++;
    if (bus.ringing !== 1'b0 || bus.led !== 16'h0000 || bus.missed !== 1'b1) begin
      failures++;
      $display("FAIL timeout: ring=%b led=%h missed=%b required 0 0000 1", bus.ringing, bus.led, bus.missed);
    end
    drive(0, 0, 0, 1, 0);
    checks++;
    if (bus.missed !== 1'b0) begin
      failures++;
      $display("FAIL stop_clears_missed: missed=%b required 0", bus.missed);
    end
  endtask

  task automatic test_snooze();
    do_reset();
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 1);
    checks++;
    if (bus.snoozing !== 1'b1 || bus.ringing !== 1'b0 || bus.led !== 16'h0000) begin
      failures++;
      $display("FAIL snooze_enter: snz=%b ring=%b led=%h required 1 0 0000", bus.snoozing, bus.ringing, bus.led);
    end
    repeat (SNOOZE_SECS - 1) drive(0, 1, 1, 0, 0);
    checks++;
    if (bus.snoozing !== 1'b1 || bus.led !== 16'h0000) begin
      failures++;
      $display("FAIL snooze_hold: snz=%b led=%h required 1 0000", bus.snoozing, bus.led);
    end
    drive(0, 1, 0, 0, 0);
    checks++;
    if (bus.ringing !== 1'b1 || bus.snoozing !== 1'b0 || bus.led !== 16'h0001) begin
      failures++;
      $display("FAIL re_ring: ring=%b snz=%b led=%h required 1 0 0001", bus.ringing, bus.snoozing, bus.led);
    end
  endtask

  task automatic test_max_snooze();
    do_reset();
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    for (int k = 0; k < MAX_SNOOZE; k++) begin
      drive(0, 0, 0, 0, 1);
      checks++;
      if (bus.snoozing !== 1'b1) begin
        failures++;
        $display("FAIL snooze_n%0d: snz=%b required 1", k, bus.snoozing);
      end
      repeat (SNOOZE_SECS) drive(0, 1, 0, 0, 0);
      checks++;
      if (bus.ringing !== 1'b1) begin
        failures++;
        $display("FAIL re_ring_n%0d: ring=%b required 1", k, bus.ringing);
      end
    end
    drive(0, 0, 0, 0, 1);
    checks++;
    if (bus.ringing !== 1'b1 || bus.snoozing !== 1'b0 || bus.led !== 16'h0001) begin
      failures++;
      $display("FAIL snooze_exhausted: ring=%b snz=%b led=%h required 1 0 0001", bus.ringing, bus.snoozing, bus.led);
    end
    drive(0, 0, 0, 1, 0);
    checks++;
    if (bus.ringing !== 1'b0 || bus.missed !== 1'b0 || bus.led !== 16'h0000) begin
      failures++;
      $display("FAIL stop_after_max: ring=%b missed=%b led=%h required 0 0 0000", bus.ringing, bus.missed, bus.led);
    end
  endtask

  task automatic test_priority();
    do_reset();
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 1);
    checks++;
    if (bus.ringing !== 1'b0 || bus.snoozing !== 1'b0) begin
      failures++;
      $display("FAIL stop_beats_snooze: ring=%b snz=%b required 0 0", bus.ringing, bus.snoozing);
    end
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    checks++;
    if (bus.ringing !== 1'b1 || bus.led !== 16'h0001 || bus.snoozing !== 1'b0) begin
      failures++;
      $display("FAIL trig_in_snooze: ring=%b led=%h snz=%b required 1 0001 0", bus.ringing, bus.led, bus.snoozing);
    end
    repeat (RING_SECS - 1) drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    checks++;
    if (bus.ringing !== 1'b0 || bus.missed !== 1'b1) begin
      failures++;
      $display("FAIL fresh_ring_timeout: ring=%b missed=%b required 0 1", bus.ringing, bus.missed);
    end
    drive(0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 0);
    checks++;
    if (bus.ringing !== 1'b0 || bus.snoozing !== 1'b0) begin
      failures++;
      $display("FAIL stop_beats_trig_snooze: ring=%b snz=%b required 0 0", bus.ringing, bus.snoozing);
    end
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (2) drive(1, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    checks++;
    if (bus.ringing !== 1'b1) begin
      failures++;
      $display("FAIL ring_trig_3s: ring=%b required 1", bus.ringing);
    end
    drive(1, 1, 0, 0, 0);
    checks++;
    if (bus.ringing !== 1'b0 || bus.missed !== 1'b1) begin
      failures++;
      $display("FAIL ring_trig_no_restart: ring=%b missed=%b required 0 1", bus.ringing, bus.missed);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1, 0, 0, 0, 0);
    repeat (6) drive(1, 0, 1, 0, 0);
    checks++;
    if (bus.led !== 16'h0040) begin
      failures++;
      $display("FAIL pre_reset_led: led=%h required 0040", bus.led);
    end
    #2;
    CR = 1'b1;
    #1;
    checks++;
    if (bus.led !== 16'h0000 || bus.ringing !== 1'b0) begin
      failures++;
      $display("FAIL async_abort: led=%h ring=%b required 0000 0", bus.led, bus.ringing);
    end
    @(posedge clk);
    bus.start_light_alarm = 0;
    bus.tick_fast = 0;
    @(negedge clk);
    CR = 1'b0;
    model_reset();
    repeat (2) drive(0, 0, 0, 0, 0);
    checks++;
    if (bus.ringing !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle: ring=%b required 0", bus.ringing);
    end
    drive(1, 0, 0, 0, 0);
    checks++;
    if (bus.ringing !== 1'b1 || bus.led !== 16'h0001) begin
      failures++;
      $display("FAIL post_reset_rise: ring=%b led=%h required 1 0001", bus.ringing, bus.led);
    end
  endtask

  task automatic test_random();
    bit s;
    do_reset();
    s = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) s = ~s;
      drive(s, ($urandom_range(3) == 0), $urandom_range(1),
            ($urandom_range(19) == 0), ($urandom_range(7) == 0));
      checks++;
      if (bus.led !== model_led() || bus.ringing !== m_ring ||
          bus.snoozing !== m_snz || bus.missed !== m_missed) begin
        failures++;
        $display("FAIL random_c%0d: led=%h ring=%b snz=%b missed=%b required %h %b %b %b",
                 i, bus.led, bus.ringing, bus.snoozing, bus.missed,
                 model_led(), m_ring, m_snz, m_missed);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    CR       = 1'b1;
    model_reset();
    test_reset();
    test_trigger();
    test_timeout();
    test_snooze();
    test_max_snooze();
    test_priority();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alarm_light_driver.md
Name: alarm_light_driver

Overview:
Consumer side of the alarm match signal. Takes the level start_light_alarm produced by the alarm comparator, edge-detects it, and runs the wake-up sequence: a chasing LED pattern for a bounded ring time, with user stop and snooze and automatic re-ring after snooze. Sits between the alarm comparator and the board LEDs/status outputs, clocked from the system clock with 1 Hz and fast enable ticks from the clock divider.

Parameters:
LED_W, 16, width of LED bar driven by chase pattern (>=2)
RING_SECS, 60, seconds a ring lasts before auto-timeout
SNOOZE_SECS, 300, seconds in snooze before re-ring
MAX_SNOOZE, 3, snoozes allowed per alarm event; further snooze presses act as no-op

Ports:
clk  input  1  system clock
CR  input  1  asynchronous active-high reset
tick_1hz  input  1  one-clk enable pulse per second
tick_fast  input  1  one-clk enable pulse for chase step (e.g. 8 Hz)
start_light_alarm  input  1  level from alarm comparator; high while time matches
stop_btn  input  1  debounced one-clk pulse: dismiss
snooze_btn  input  1  debounced one-clk pulse: snooze
led  output  LED_W  chase pattern; all zero when not ringing
ringing  output  1  high in RING
snoozing  output  1  high in SNOOZE
missed  output  1  sticky: a ring timed out without stop/snooze

Behaviour:
- Async reset (CR=1): state IDLE, led=0, ringing=0, snoozing=0, missed=0, all counters 0, edge-detect register 0. Reset mid-ring aborts immediately.
- Trigger: registered copy start_d; trig = start_light_alarm & ~start_d. Level held high does not retrigger.
- States: IDLE, RING, SNOOZE. Outputs registered; visible one clk after transition.
- IDLE: trig -> RING; sec_cnt=0, snooze_cnt=0, led=1 (bit0). stop_btn in IDLE clears missed.
- RING: tick_fast rotates led left by 1 (MSB wraps to bit0). tick_1hz increments sec_cnt. Priority per clk: stop_btn > snooze_btn > timeout.
  - stop_btn -> IDLE, led=0.
  - snooze_btn with snooze_cnt < MAX_SNOOZE -> SNOOZE, snooze_cnt++, sec_cnt=0, led=0. With snooze_cnt == MAX_SNOOZE: ignored, keep ringing.
  - tick_1hz while sec_cnt == RING_SECS-1 -> IDLE, missed=1, led=0.
  - trig while in RING: ignored (no restart of sec_cnt).
- SNOOZE: led=0. tick_1hz increments sec_cnt; tick_1hz while sec_cnt == SNOOZE_SECS-1 -> RING, sec_cnt=0, led=1. stop_btn -> IDLE. trig (new alarm) -> RING immediately, sec_cnt=0, led=1, snooze_cnt kept. snooze_btn ignored.
- Simultaneous stop_btn and trig in IDLE: trig wins (enter RING). In SNOOZE stop_btn beats trig.
- tick_fast and tick_1hz in same clk in RING: both applied.
- Counter widths: sec_cnt sized for max(RING_SECS, SNOOZE_SECS)-1; snooze_cnt sized for MAX_SNOOZE; no wrap possible within legal operation.
- ringing=(state==RING), snoozing=(state==SNOOZE), registered.

Test Plan:
- Reset then start_light_alarm high for 20 clk: exactly one entry to RING, led=0x0001, ringing=1; after 3 tick_fast led=0x0008; after 16 tick_fast led wraps to 0x0001.
- RING_SECS=4: no buttons, 4 tick_1hz -> IDLE, led=0, missed=1; stop_btn in IDLE -> missed=0.
- Ring, snooze_btn -> snoozing=1, led=0; SNOOZE_SECS=3, 3 tick_1hz -> ringing=1, led=0x0001.
- MAX_SNOOZE=2: snooze twice with re-rings, third snooze_btn -> stays RING; stop_btn -> IDLE, missed=0.
- stop_btn and snooze_btn same clk in RING -> IDLE; trig in SNOOZE -> RING immediately; trig during RING after 2 s -> timeout still at RING_SECS from original start.
- Assert CR mid-RING with led=0x0040 -> led=0, ringing=0 same cycle without clk edge; start_light_alarm still high after release -> no retrigger until it drops and rises.
